// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if: dispatch, CDB broadcast and ALU issue bundle for the
// integer ALU issue queue. The master side is the producer of dispatch ops and
// CDB broadcasts and the consumer of issued ops; the slave side is the queue.
interface alu_issue_queue_if #(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
);
  // dispatch port
  logic             disp_valid;
  logic             disp_ready;
  logic             disp_src1_rdy;
  logic [TAG_W-1:0] disp_src1_tag;
  logic [XLEN-1:0]  disp_src1;
  logic             disp_src2_rdy;
  logic [TAG_W-1:0] disp_src2_tag;
  logic [XLEN-1:0]  disp_src2;
  logic             disp_dst_valid;
  logic [TAG_W-1:0] disp_dst_tag;
  logic [2:0]       disp_alu_ctrl;
  logic             disp_funct7;
  logic             disp_pred;
  logic [XLEN-1:0]  disp_target;
  // common data bus broadcast
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  // issue port toward the ALU
  logic             issue_valid;
  logic             issue_ready;
  logic [XLEN-1:0]  src_1;
  logic [XLEN-1:0]  src_2;
  logic             dst_valid;
  logic [TAG_W-1:0] dst_tag;
  logic [2:0]       alu_ctrl;
  logic             funct7;
  logic             pred;
  logic [XLEN-1:0]  target;

  modport master (
    output disp_valid, disp_src1_rdy, disp_src1_tag, disp_src1,
           disp_src2_rdy, disp_src2_tag, disp_src2, disp_dst_valid,
           disp_dst_tag, disp_alu_ctrl, disp_funct7, disp_pred, disp_target,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  disp_ready, issue_valid, src_1, src_2, dst_valid, dst_tag,
           alu_ctrl, funct7, pred, target
  );

  modport slave (
    input  disp_valid, disp_src1_rdy, disp_src1_tag, disp_src1,
           disp_src2_rdy, disp_src2_tag, disp_src2, disp_dst_valid,
           disp_dst_tag, disp_alu_ctrl, disp_funct7, disp_pred, disp_target,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    output disp_ready, issue_valid, src_1, src_2, dst_valid, dst_tag,
           alu_ctrl, funct7, pred, target
  );
endinterface

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: age-ordered compacting issue queue for the integer ALU.
// Entry 0 is always the oldest; entries 0..count-1 are valid. Operands wake
// on CDB tag match and become eligible the cycle after capture. The oldest
// entry with both operands ready is presented to the ALU; on acceptance it is
// removed and younger entries shift down by one.
// Optional build macro ALU_IQ_OCC_EN adds the occupancy and almost_full ports.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  alu_issue_queue_if.slave             iq
`ifdef ALU_IQ_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         almost_full
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             src1_rdy;
    logic [TAG_W-1:0] src1_tag;
    logic [XLEN-1:0]  src1;
    logic             src2_rdy;
    logic [TAG_W-1:0] src2_tag;
    logic [XLEN-1:0]  src2;
    logic             dst_valid;
    logic [TAG_W-1:0] dst_tag;
    logic [2:0]       alu_ctrl;
    logic             funct7;
    logic             pred;
    logic [XLEN-1:0]  target;
  } entry_t;

  entry_t           ent_r [DEPTH];
  entry_t           ent_s [DEPTH];
  entry_t           new_ent_s;
  entry_t           issue_ent_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] base_cnt_s;
  logic [DEPTH-1:0] elig_s;
  logic [DEPTH-1:0] shift_s;
  logic             sel_any_s;
  logic             issue_valid_s;
  logic             issue_fire_s;
  logic             disp_ready_s;
  logic             disp_fire_s;

  // A full queue refuses dispatch even when an issue frees a slot this cycle.
  assign disp_ready_s  = (cnt_r < CNT_W'(DEPTH)) && !rst;
  assign disp_fire_s   = iq.disp_valid && disp_ready_s && !flush;
  assign issue_valid_s = sel_any_s && !flush && !rst;
  assign issue_fire_s  = issue_valid_s && iq.issue_ready;
  assign iq.disp_ready  = disp_ready_s;
  assign iq.issue_valid = issue_valid_s;

  // Oldest-first select; shift_s marks slots at or above the selected entry.
  always_comb begin
    elig_s      = '0;
    shift_s     = '0;
    sel_any_s   = 1'b0;
    issue_ent_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig_s[i] = (CNT_W'(i) < cnt_r) && ent_r[i].src1_rdy && ent_r[i].src2_rdy;
      if (elig_s[i] && !sel_any_s) begin
        issue_ent_s = ent_r[i];
      end else begin
        issue_ent_s = issue_ent_s;
      end
      sel_any_s  = sel_any_s | elig_s[i];
      shift_s[i] = sel_any_s;
    end
  end

  // Issue fields come straight from the selected entry and idle at zero.
  always_comb begin
    if (issue_valid_s) begin
      iq.src_1     = issue_ent_s.src1;
      iq.src_2     = issue_ent_s.src2;
      iq.dst_valid = issue_ent_s.dst_valid;
      iq.dst_tag   = issue_ent_s.dst_tag;
      iq.alu_ctrl  = issue_ent_s.alu_ctrl;
      iq.funct7    = issue_ent_s.funct7;
      iq.pred      = issue_ent_s.pred;
      iq.target    = issue_ent_s.target;
    end else begin
      iq.src_1     = '0;
      iq.src_2     = '0;
      iq.dst_valid = 1'b0;
      iq.dst_tag   = '0;
      iq.alu_ctrl  = 3'd0;
      iq.funct7    = 1'b0;
      iq.pred      = 1'b0;
      iq.target    = '0;
    end
  end

  // Build the incoming entry, catching a broadcast that lands in its dispatch cycle.
  always_comb begin
    new_ent_s.src1_rdy  = iq.disp_src1_rdy;
    new_ent_s.src1_tag  = iq.disp_src1_tag;
    new_ent_s.src1      = iq.disp_src1;
    new_ent_s.src2_rdy  = iq.disp_src2_rdy;
    new_ent_s.src2_tag  = iq.disp_src2_tag;
    new_ent_s.src2      = iq.disp_src2;
    new_ent_s.dst_valid = iq.disp_dst_valid;
    new_ent_s.dst_tag   = iq.disp_dst_tag;
    new_ent_s.alu_ctrl  = iq.disp_alu_ctrl;
    new_ent_s.funct7    = iq.disp_funct7;
    new_ent_s.pred      = iq.disp_pred;
    new_ent_s.target    = iq.disp_target;
    if (iq.cdb_valid && !iq.disp_src1_rdy && (iq.disp_src1_tag == iq.cdb_tag)) begin
      new_ent_s.src1_rdy = 1'b1;
      new_ent_s.src1     = iq.cdb_data;
    end else begin
      new_ent_s.src1_rdy = iq.disp_src1_rdy;
    end
    if (iq.cdb_valid && !iq.disp_src2_rdy && (iq.disp_src2_tag == iq.cdb_tag)) begin
      new_ent_s.src2_rdy = 1'b1;
      new_ent_s.src2     = iq.cdb_data;
    end else begin
      new_ent_s.src2_rdy = iq.disp_src2_rdy;
    end
  end

  // Next queue state: wakeup, then compaction on issue, then tail write, flush last.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_s[i] = ent_r[i];
      if (iq.cdb_valid && !ent_r[i].src1_rdy && (ent_r[i].src1_tag == iq.cdb_tag)) begin
        ent_s[i].src1_rdy = 1'b1;
        ent_s[i].src1     = iq.cdb_data;
      end else begin
        ent_s[i].src1_rdy = ent_r[i].src1_rdy;
      end
      if (iq.cdb_valid && !ent_r[i].src2_rdy && (ent_r[i].src2_tag == iq.cdb_tag)) begin
        ent_s[i].src2_rdy = 1'b1;
        ent_s[i].src2     = iq.cdb_data;
      end else begin
        ent_s[i].src2_rdy = ent_r[i].src2_rdy;
      end
    end
    if (issue_fire_s) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_s[i] = shift_s[i] ? ent_s[i+1] : ent_s[i];
      end
      base_cnt_s = cnt_r - CNT_W'(1);
    end else begin
      base_cnt_s = cnt_r;
    end
    if (disp_fire_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_s[i] = (CNT_W'(i) == base_cnt_s) ? new_ent_s : ent_s[i];
      end
      cnt_s = base_cnt_s + CNT_W'(1);
    end else begin
      cnt_s = base_cnt_s;
    end
    if (flush) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_s;
    end
  end

  // Queue storage and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
    end else begin
      cnt_r <= cnt_s;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= ent_s[i];
      end
    end
  end

`ifdef ALU_IQ_OCC_EN
  assign occupancy   = cnt_r;
  assign almost_full = (cnt_r >= CNT_W'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed self-checking bench for alu_issue_queue
// (DEPTH=4, TAG_W=4, XLEN=32). Inputs change 2 time units after the rising
// edge; outputs are checked 1 time unit after that.
module tb_alu_issue_queue;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  alu_issue_queue_if #(.TAG_W(4), .XLEN(32)) iq_bus ();

`ifdef ALU_IQ_OCC_EN
  logic [2:0] occupancy;
  logic       almost_full;
`endif

  alu_issue_queue #(.DEPTH(4), .TAG_W(4), .XLEN(32)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .iq    (iq_bus.slave)
`ifdef ALU_IQ_OCC_EN
    ,
    .occupancy   (occupancy),
    .almost_full (almost_full)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic disp_op(input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                         input logic r2, input logic [3:0] t2, input logic [31:0] v2,
                         input logic [3:0] dt, input logic [2:0] ctrl);
    iq_bus.disp_valid     = 1'b1;
    iq_bus.disp_src1_rdy  = r1;
    iq_bus.disp_src1_tag  = t1;
    iq_bus.disp_src1      = v1;
    iq_bus.disp_src2_rdy  = r2;
    iq_bus.disp_src2_tag  = t2;
    iq_bus.disp_src2      = v2;
    iq_bus.disp_dst_valid = 1'b1;
    iq_bus.disp_dst_tag   = dt;
    iq_bus.disp_alu_ctrl  = ctrl;
    iq_bus.disp_funct7    = 1'b0;
    iq_bus.disp_pred      = 1'b0;
    iq_bus.disp_target    = 32'd0;
  endtask

  task automatic cdb(input logic v, input logic [3:0] t, input logic [31:0] d);
    iq_bus.cdb_valid = v;
    iq_bus.cdb_tag   = t;
    iq_bus.cdb_data  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    disp_op(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 3'd0);
    iq_bus.disp_valid  = 1'b0;
    iq_bus.issue_ready = 1'b0;
    cdb(1'b0, 4'd0, 32'd0);

    // reset state
    cyc();
    cyc();
    #1;
    check("rst_disp_ready", 64'(iq_bus.disp_ready), 64'd0);
    check("rst_issue_valid", 64'(iq_bus.issue_valid), 64'd0);
    check("rst_src_1", 64'(iq_bus.src_1), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_disp_ready", 64'(iq_bus.disp_ready), 64'd1);
    check("post_rst_issue_valid", 64'(iq_bus.issue_valid), 64'd0);
`ifdef ALU_IQ_OCC_EN
    check("post_rst_occupancy", 64'(occupancy), 64'd0);
`endif

    // simple ready ADD
    cyc();
    iq_bus.issue_ready = 1'b1;
    disp_op(1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 4'd1, 3'd0);
    cyc();
    iq_bus.disp_valid = 1'b0;
    #1;
    check("add_issue_valid", 64'(iq_bus.issue_valid), 64'd1);
    check("add_src_1", 64'(iq_bus.src_1), 64'd5);
    check("add_src_2", 64'(iq_bus.src_2), 64'd7);
    check("add_alu_ctrl", 64'(iq_bus.alu_ctrl), 64'd0);
    check("add_dst_tag", 64'(iq_bus.dst_tag), 64'd1);
    cyc();
    #1;
    check("add_drained", 64'(iq_bus.issue_valid), 64'd0);
    check("idle_src_1", 64'(iq_bus.src_1), 64'd0);

    // src2 waits on tag 3, broadcast two cycles later
    disp_op(1'b1, 4'd0, 32'd9, 1'b0, 4'd3, 32'd0, 4'd2, 3'd4);
    cyc();
    iq_bus.disp_valid = 1'b0;
    #1;
    check("wait_not_ready", 64'(iq_bus.issue_valid), 64'd0);
    cyc();
    cdb(1'b1, 4'd3, 32'h10);
    #1;
    check("wake_same_cycle", 64'(iq_bus.issue_valid), 64'd0);
    cyc();
    cdb(1'b0, 4'd0, 32'd0);
    #1;
    check("wake_issue_valid", 64'(iq_bus.issue_valid), 64'd1);
    check("wake_src_2", 64'(iq_bus.src_2), 64'h10);
    check("wake_src_1", 64'(iq_bus.src_1), 64'd9);
    check("wake_alu_ctrl", 64'(iq_bus.alu_ctrl), 64'd4);
    cyc();
    #1;
    check("wake_drained", 64'(iq_bus.issue_valid), 64'd0);

    // fill the queue with issue stalled
    iq_bus.issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp_op(1'b1, 4'd0, 32'(10 + k), 1'b1, 4'd0, 32'(100 + k), 4'(4 + k), 3'd0);
      cyc();
    end
    disp_op(1'b1, 4'd0, 32'h99, 1'b1, 4'd0, 32'h99, 4'd15, 3'd0);
    #1;
    check("full_disp_ready", 64'(iq_bus.disp_ready), 64'd0);
    check("full_head_src_1", 64'(iq_bus.src_1), 64'd10);
`ifdef ALU_IQ_OCC_EN
    check("full_occupancy", 64'(occupancy), 64'd4);
    check("full_almost_full", 64'(almost_full), 64'd1);
`endif
    cyc();
    #1;
    check("stall_hold_src_1", 64'(iq_bus.src_1), 64'd10);
    check("stall_hold_valid", 64'(iq_bus.issue_valid), 64'd1);
    iq_bus.issue_ready = 1'b1;
    #1;
    check("full_issue_disp_ready", 64'(iq_bus.disp_ready), 64'd0);
    cyc();
    iq_bus.disp_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      check("order_src_1", 64'(iq_bus.src_1), 64'(10 + k));
      check("order_dst_tag", 64'(iq_bus.dst_tag), 64'(4 + k));
      cyc();
    end
    #1;
    check("order_no_extra", 64'(iq_bus.issue_valid), 64'd0);

    // younger ready op overtakes a waiting elder; waiting ones keep their order
    disp_op(1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'd2, 4'd8, 3'd0);
    cyc();
    disp_op(1'b1, 4'd0, 32'd20, 1'b1, 4'd0, 32'd21, 4'd9, 3'd0);
    cyc();
    disp_op(1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'd3, 4'd10, 3'd0);
    #1;
    check("ooo_first_valid", 64'(iq_bus.issue_valid), 64'd1);
    check("ooo_first_dst", 64'(iq_bus.dst_tag), 64'd9);
    check("ooo_first_src_1", 64'(iq_bus.src_1), 64'd20);
    cyc();
    iq_bus.disp_valid = 1'b0;
    #1;
    check("ooo_both_wait", 64'(iq_bus.issue_valid), 64'd0);
    cdb(1'b1, 4'd5, 32'h55);
    cyc();
    cdb(1'b0, 4'd0, 32'd0);
    #1;
    check("ooo_elder_dst", 64'(iq_bus.dst_tag), 64'd8);
    check("ooo_elder_src_1", 64'(iq_bus.src_1), 64'h55);
    cyc();
    #1;
    check("ooo_third_dst", 64'(iq_bus.dst_tag), 64'd10);
    check("ooo_third_src_2", 64'(iq_bus.src_2), 64'd3);
    cyc();
    #1;
    check("ooo_drained", 64'(iq_bus.issue_valid), 64'd0);

    // flush with three queued and a dispatch in the flush cycle
    iq_bus.issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp_op(1'b1, 4'd0, 32'(48 + k), 1'b1, 4'd0, 32'd1, 4'd1, 3'd0);
      cyc();
    end
    flush = 1'b1;
    disp_op(1'b1, 4'd0, 32'h99, 1'b1, 4'd0, 32'd1, 4'd1, 3'd0);
    #1;
    check("flush_cycle_valid", 64'(iq_bus.issue_valid), 64'd0);
    cyc();
    flush = 1'b0;
    iq_bus.disp_valid = 1'b0;
    #1;
    check("post_flush_valid", 64'(iq_bus.issue_valid), 64'd0);
    check("post_flush_disp_ready", 64'(iq_bus.disp_ready), 64'd1);
`ifdef ALU_IQ_OCC_EN
    check("post_flush_occupancy", 64'(occupancy), 64'd0);
`endif
    iq_bus.issue_ready = 1'b1;
    disp_op(1'b1, 4'd0, 32'h77, 1'b1, 4'd0, 32'd1, 4'd2, 3'd0);
    cyc();
    iq_bus.disp_valid = 1'b0;
    #1;
    check("post_flush_head", 64'(iq_bus.src_1), 64'h77);
    cyc();
    #1;
    check("post_flush_empty", 64'(iq_bus.issue_valid), 64'd0);

    // broadcast in the dispatch cycle
    disp_op(1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd4, 4'd3, 3'd1);
    cdb(1'b1, 4'd6, 32'hABCD);
    cyc();
    iq_bus.disp_valid = 1'b0;
    cdb(1'b0, 4'd0, 32'd0);
    #1;
    check("disp_wake_valid", 64'(iq_bus.issue_valid), 64'd1);
    check("disp_wake_src_1", 64'(iq_bus.src_1), 64'hABCD);
    cyc();

    // both operands wake on one broadcast
    disp_op(1'b0, 4'd2, 32'd0, 1'b0, 4'd2, 32'd0, 4'd4, 3'd0);
    cyc();
    iq_bus.disp_valid = 1'b0;
    cdb(1'b1, 4'd2, 32'h42);
    cyc();
    cdb(1'b0, 4'd0, 32'd0);
    #1;
    check("dual_wake_src_1", 64'(iq_bus.src_1), 64'h42);
    check("dual_wake_src_2", 64'(iq_bus.src_2), 64'h42);
    cyc();

    // reset mid-operation
    iq_bus.issue_ready = 1'b0;
    disp_op(1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'd1, 3'd0);
    cyc();
    iq_bus.disp_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(iq_bus.issue_valid), 64'd0);
    check("mid_rst_src_1", 64'(iq_bus.src_1), 64'd0);
    check("mid_rst_disp_ready", 64'(iq_bus.disp_ready), 64'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("after_mid_rst_valid", 64'(iq_bus.issue_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
